axi_lite_xbar_1to2: RTL and testbench

AXI4-Lite address decoder with one upstream master port and two downstream slave ports, plus an internal error responder for unmapped addresses. It sits between the arbitrated core bus and the memory/peripheral slaves, e.g. SRAM on `s0` and UART on `s1`. It allows one outstanding read and one outstanding write. The read and write paths are independent and may be busy at the same time.

---
 rtl/axi_lite_xbar_1to2_if.sv | 30 +++
 rtl/axi_lite_xbar_1to2.sv | 176 +++++++++++++++++
 tb/tb_axi_lite_xbar_1to2.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_xbar_1to2_if.sv
// AXI4-Lite bus bundle: 32-bit address/data, 4-bit write mask, 2-bit response.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_xbar_1to2.sv
// AXI4-Lite 1-to-2 address decoder with a built-in DECERR responder for unmapped addresses.
// Read FSM: RD_IDLE/RD_WAIT/RD_ERR; write FSM: WR_IDLE/WR_DATA/WR_RESP. All forwarding is combinational.
module axi_lite_xbar_1to2 #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_SIZE = 32'h0800_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    axi_lite_if.slave   m,
    axi_lite_if.master  s0,
    axi_lite_if.master  s1
);
    localparam logic [1:0] SEL_S0  = 2'd0;
    localparam logic [1:0] SEL_S1  = 2'd1;
    localparam logic [1:0] SEL_ERR = 2'd2;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_ERR} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t  rd_state, rd_next;
    wr_state_t  wr_state, wr_next;
    logic       rd_sel, rd_sel_next;
    logic [1:0] wr_sel, wr_sel_next;
    logic [1:0] rd_dec, wr_dec;

    // Unsigned wrap makes addresses below a base miss; S0 wins on overlap.
    function automatic logic [1:0] dec(input logic [31:0] addr);
        if (addr - S0_BASE < S0_SIZE)      return SEL_S0;
        else if (addr - S1_BASE < S1_SIZE) return SEL_S1;
        else                               return SEL_ERR;
    endfunction

    assign rd_dec = dec(m.araddr);
    assign wr_dec = dec(m.awaddr);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rd_sel   <= 1'b0;
            wr_state <= WR_IDLE;
            wr_sel   <= SEL_S0;
        end else begin
            rd_state <= rd_next;
            rd_sel   <= rd_sel_next;
            wr_state <= wr_next;
            wr_sel   <= wr_sel_next;
        end
    end

    always_comb begin
        rd_next     = rd_state;
        rd_sel_next = rd_sel;
        case (rd_state)
            RD_IDLE: if (m.arvalid && m.arready) begin
                rd_next     = (rd_dec == SEL_ERR) ? RD_ERR : RD_WAIT;
                rd_sel_next = rd_dec[0];
            end
            RD_WAIT: if (m.rvalid && m.rready) rd_next = RD_IDLE;
            RD_ERR:  if (m.rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s0.araddr  = m.araddr;
        s1.araddr  = m.araddr;
        s0.arvalid = 1'b0;
        s1.arvalid = 1'b0;
        s0.rready  = 1'b0;
        s1.rready  = 1'b0;
        m.arready  = 1'b0;
        m.rvalid   = 1'b0;
        m.rdata    = '0;
        m.rresp    = '0;
        if (!reset) begin
            case (rd_state)
                RD_IDLE: begin
                    case (rd_dec)
                        SEL_S0:  begin s0.arvalid = m.arvalid; m.arready = s0.arready; end
                        SEL_S1:  begin s1.arvalid = m.arvalid; m.arready = s1.arready; end
                        default: m.arready = 1'b1;
                    endcase
                end
                RD_WAIT: begin
                    if (!rd_sel) begin
                        m.rvalid = s0.rvalid; m.rdata = s0.rdata; m.rresp = s0.rresp;
                        s0.rready = m.rready;
                    end else begin
                        m.rvalid = s1.rvalid; m.rdata = s1.rdata; m.rresp = s1.rresp;
                        s1.rready = m.rready;
                    end
                end
                RD_ERR: begin
                    m.rvalid = 1'b1;
                    m.rresp  = 2'b11;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_next     = wr_state;
        wr_sel_next = wr_sel;
        case (wr_state)
            WR_IDLE: if (m.awvalid && m.awready) begin
                wr_next     = (m.wvalid && m.wready) ? WR_RESP : WR_DATA;
                wr_sel_next = wr_dec;
            end
            WR_DATA: if (m.wvalid && m.wready) wr_next = WR_RESP;
            WR_RESP: if (m.bvalid && m.bready) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        s0.awaddr  = m.awaddr;
        s1.awaddr  = m.awaddr;
        s0.wdata   = m.wdata;
        s1.wdata   = m.wdata;
        s0.wmask   = m.wmask;
        s1.wmask   = m.wmask;
        s0.awvalid = 1'b0;
        s1.awvalid = 1'b0;
        s0.wvalid  = 1'b0;
        s1.wvalid  = 1'b0;
        s0.bready  = 1'b0;
        s1.bready  = 1'b0;
        m.awready  = 1'b0;
        m.wready   = 1'b0;
        m.bvalid   = 1'b0;
        m.bresp    = '0;
        if (!reset) begin
            case (wr_state)
                // W only travels alongside a valid AW so it cannot reach a slave ahead of its address.
                WR_IDLE: begin
                    case (wr_dec)
                        SEL_S0: begin
                            s0.awvalid = m.awvalid;
                            s0.wvalid  = m.wvalid && m.awvalid;
                            m.awready  = s0.awready;
                            m.wready   = s0.wready && m.awvalid;
                        end
                        SEL_S1: begin
                            s1.awvalid = m.awvalid;
                            s1.wvalid  = m.wvalid && m.awvalid;
                            m.awready  = s1.awready;
                            m.wready   = s1.wready && m.awvalid;
                        end
                        default: begin
                            m.awready = 1'b1;
                            m.wready  = m.awvalid;
                        end
                    endcase
                end
                WR_DATA: begin
                    case (wr_sel)
                        SEL_S0:  begin s0.wvalid = m.wvalid; m.wready = s0.wready; end
                        SEL_S1:  begin s1.wvalid = m.wvalid; m.wready = s1.wready; end
                        default: m.wready = 1'b1;
                    endcase
                end
                WR_RESP: begin
                    case (wr_sel)
                        SEL_S0:  begin m.bvalid = s0.bvalid; m.bresp = s0.bresp; s0.bready = m.bready; end
                        SEL_S1:  begin m.bvalid = s1.bvalid; m.bresp = s1.bresp; s1.bready = m.bready; end
                        default: begin m.bvalid = 1'b1; m.bresp = 2'b11; end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_xbar_1to2.sv
// Directed bench for axi_lite_xbar_1to2: decode vector table plus hand-written multi-cycle sequences.
module tb_axi_lite_xbar_1to2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    axi_lite_if m_bus ();
    axi_lite_if s0_bus ();
    axi_lite_if s1_bus ();

    axi_lite_xbar_1to2 dut (
        .clk   (clk),
        .reset (reset),
        .m     (m_bus),
        .s0    (s0_bus),
        .s1    (s1_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        bit          rdy;
        bit          s0v;
        bit          s1v;
        bit          mrdy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_all();
        m_bus.awaddr = '0; m_bus.awvalid = 0; m_bus.wdata = '0; m_bus.wmask = '0;
        m_bus.wvalid = 0; m_bus.bready = 0; m_bus.araddr = '0; m_bus.arvalid = 0;
        m_bus.rready = 0;
        s0_bus.awready = 0; s0_bus.wready = 0; s0_bus.bvalid = 0; s0_bus.bresp = '0;
        s0_bus.arready = 0; s0_bus.rvalid = 0; s0_bus.rdata = '0; s0_bus.rresp = '0;
        s1_bus.awready = 0; s1_bus.wready = 0; s1_bus.bvalid = 0; s1_bus.bresp = '0;
        s1_bus.arready = 0; s1_bus.rvalid = 0; s1_bus.rdata = '0; s1_bus.rresp = '0;
    endtask

    task automatic drive_busy();
        m_bus.arvalid = 1; m_bus.awvalid = 1; m_bus.wvalid = 1; m_bus.rready = 1; m_bus.bready = 1;
        s0_bus.arready = 1; s0_bus.awready = 1; s0_bus.wready = 1; s0_bus.rvalid = 1; s0_bus.bvalid = 1;
        s1_bus.arready = 1; s1_bus.awready = 1; s1_bus.wready = 1; s1_bus.rvalid = 1; s1_bus.bvalid = 1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " m.arready"}, m_bus.arready, 0);
        chk({tag, " m.awready"}, m_bus.awready, 0);
        chk({tag, " m.wready"},  m_bus.wready, 0);
        chk({tag, " m.rvalid"},  m_bus.rvalid, 0);
        chk({tag, " m.bvalid"},  m_bus.bvalid, 0);
        chk({tag, " s0.arvalid"}, s0_bus.arvalid, 0);
        chk({tag, " s0.awvalid"}, s0_bus.awvalid, 0);
        chk({tag, " s0.wvalid"},  s0_bus.wvalid, 0);
        chk({tag, " s0.rready"},  s0_bus.rready, 0);
        chk({tag, " s0.bready"},  s0_bus.bready, 0);
        chk({tag, " s1.arvalid"}, s1_bus.arvalid, 0);
        chk({tag, " s1.awvalid"}, s1_bus.awvalid, 0);
        chk({tag, " s1.wvalid"},  s1_bus.wvalid, 0);
        chk({tag, " s1.rready"},  s1_bus.rready, 0);
        chk({tag, " s1.bready"},  s1_bus.bready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // addr, wr, slave ready, exp s0 valid, exp s1 valid, exp upstream ready
        vecs[0] = '{32'h8000_0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h87FF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h8800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h1000_0FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h1000_1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        clear_all();
        drive_busy();
        @(negedge clk);
        chk_quiet("reset");
        @(negedge clk);
        clear_all();
        reset = 0;

        // Decode table: valids are withdrawn before the next rising edge, so no handshake occurs.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s0_bus.arready = vecs[i].rdy; s1_bus.arready = vecs[i].rdy;
            s0_bus.awready = vecs[i].rdy; s1_bus.awready = vecs[i].rdy;
            s0_bus.wready  = vecs[i].rdy; s1_bus.wready  = vecs[i].rdy;
            if (!vecs[i].wr) begin
                m_bus.araddr = vecs[i].addr; m_bus.arvalid = 1;
            end else begin
                m_bus.awaddr = vecs[i].addr; m_bus.awvalid = 1; m_bus.wvalid = 1;
            end
            #1;
            if (!vecs[i].wr) begin
                chk($sformatf("vec%0d s0.arvalid", i), s0_bus.arvalid, vecs[i].s0v);
                chk($sformatf("vec%0d s1.arvalid", i), s1_bus.arvalid, vecs[i].s1v);
                chk($sformatf("vec%0d m.arready", i), m_bus.arready, vecs[i].mrdy);
            end else begin
                chk($sformatf("vec%0d s0.awvalid", i), s0_bus.awvalid, vecs[i].s0v);
                chk($sformatf("vec%0d s1.awvalid", i), s1_bus.awvalid, vecs[i].s1v);
                chk($sformatf("vec%0d m.awready", i), m_bus.awready, vecs[i].mrdy);
                chk($sformatf("vec%0d s0.wvalid", i), s0_bus.wvalid, vecs[i].s0v);
                chk($sformatf("vec%0d s1.wvalid", i), s1_bus.wvalid, vecs[i].s1v);
                chk($sformatf("vec%0d m.wready", i), m_bus.wready, vecs[i].mrdy);
            end
            clear_all();
        end

        // Read S0 with a 3-cycle slave latency.
        @(negedge clk);
        m_bus.araddr = 32'h8000_0010; m_bus.arvalid = 1; s0_bus.arready = 1;
        #1;
        chk("rd_s0 s0.arvalid", s0_bus.arvalid, 1);
        chk("rd_s0 s1.arvalid", s1_bus.arvalid, 0);
        @(negedge clk);
        m_bus.arvalid = 0; s0_bus.arready = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rd_s0 wait%0d m.rvalid", c), m_bus.rvalid, 0);
            chk($sformatf("rd_s0 wait%0d s1.arvalid", c), s1_bus.arvalid, 0);
            @(negedge clk);
        end
        s0_bus.rvalid = 1; s0_bus.rdata = 32'hDEAD_BEEF; s0_bus.rresp = 2'b00; m_bus.rready = 1;
        m_bus.arvalid = 1; s0_bus.arready = 1;
        #1;
        chk("rd_s0 m.rvalid", m_bus.rvalid, 1);
        chk("rd_s0 m.rdata", m_bus.rdata, 32'hDEAD_BEEF);
        chk("rd_s0 m.rresp", m_bus.rresp, 0);
        chk("rd_s0 s0.rready", s0_bus.rready, 1);
        chk("rd_s0 s1.rready", s1_bus.rready, 0);
        chk("rd_s0 no AR in R cycle", m_bus.arready, 0);
        chk("rd_s0 s0.arvalid in R cycle", s0_bus.arvalid, 0);
        @(negedge clk);
        s0_bus.rvalid = 0; m_bus.rready = 0;
        #1;
        chk("rd_s0 idle m.arready", m_bus.arready, 1);
        chk("rd_s0 idle s0.arvalid", s0_bus.arvalid, 1);
        clear_all();

        // Write S1 with AW and W together.
        @(negedge clk);
        m_bus.awaddr = 32'h1000_0004; m_bus.awvalid = 1; m_bus.wvalid = 1;
        m_bus.wdata = 32'h41; m_bus.wmask = 4'b0001;
        s1_bus.awready = 1; s1_bus.wready = 1;
        #1;
        chk("wr_s1 s1.awvalid", s1_bus.awvalid, 1);
        chk("wr_s1 s1.wvalid", s1_bus.wvalid, 1);
        chk("wr_s1 s1.awaddr", s1_bus.awaddr, 32'h1000_0004);
        chk("wr_s1 s1.wdata", s1_bus.wdata, 32'h41);
        chk("wr_s1 s1.wmask", s1_bus.wmask, 4'b0001);
        chk("wr_s1 s0.awvalid", s0_bus.awvalid, 0);
        chk("wr_s1 s0.wvalid", s0_bus.wvalid, 0);
        @(negedge clk);
        m_bus.awvalid = 0; m_bus.wvalid = 0; s1_bus.awready = 0; s1_bus.wready = 0; m_bus.bready = 1;
        #1;
        chk("wr_s1 m.bvalid low", m_bus.bvalid, 0);
        chk("wr_s1 m.awready resp", m_bus.awready, 0);
        chk("wr_s1 s1.bready", s1_bus.bready, 1);
        chk("wr_s1 s0.bready", s0_bus.bready, 0);
        @(negedge clk);
        s1_bus.bvalid = 1; s1_bus.bresp = 2'b00;
        #1;
        chk("wr_s1 m.bvalid", m_bus.bvalid, 1);
        chk("wr_s1 m.bresp", m_bus.bresp, 0);
        @(negedge clk);
        s1_bus.bvalid = 0; m_bus.bready = 0; s1_bus.awready = 1;
        #1;
        chk("wr_s1 idle m.awready", m_bus.awready, 1);
        clear_all();

        // Unmapped read with rready held low for two cycles.
        @(negedge clk);
        m_bus.araddr = 32'h0000_0000; m_bus.arvalid = 1;
        #1;
        chk("rd_err m.arready", m_bus.arready, 1);
        chk("rd_err m.rvalid early", m_bus.rvalid, 0);
        @(negedge clk);
        m_bus.arvalid = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rd_err hold%0d m.rvalid", c), m_bus.rvalid, 1);
            chk($sformatf("rd_err hold%0d m.rresp", c), m_bus.rresp, 2'b11);
            chk($sformatf("rd_err hold%0d m.rdata", c), m_bus.rdata, 0);
            @(negedge clk);
        end
        m_bus.rready = 1;
        #1;
        chk("rd_err m.rvalid at rready", m_bus.rvalid, 1);
        @(negedge clk);
        m_bus.rready = 0;
        #1;
        chk("rd_err m.rvalid after", m_bus.rvalid, 0);
        clear_all();

        // Unmapped write, W two cycles after AW.
        @(negedge clk);
        m_bus.awaddr = 32'h2000_0000; m_bus.awvalid = 1;
        #1;
        chk("wr_err m.awready", m_bus.awready, 1);
        @(negedge clk);
        m_bus.awvalid = 0;
        #1;
        chk("wr_err data m.awready", m_bus.awready, 0);
        chk("wr_err data m.wready", m_bus.wready, 1);
        chk("wr_err data m.bvalid", m_bus.bvalid, 0);
        @(negedge clk);
        m_bus.wvalid = 1;
        #1;
        chk("wr_err m.wready", m_bus.wready, 1);
        chk("wr_err s0.wvalid", s0_bus.wvalid, 0);
        chk("wr_err s1.wvalid", s1_bus.wvalid, 0);
        @(negedge clk);
        m_bus.wvalid = 0;
        #1;
        chk("wr_err m.bvalid", m_bus.bvalid, 1);
        chk("wr_err m.bresp", m_bus.bresp, 2'b11);
        m_bus.bready = 1;
        @(negedge clk);
        m_bus.bready = 0;
        #1;
        chk("wr_err m.bvalid after", m_bus.bvalid, 0);

        // Unmapped write with AW and W together.
        @(negedge clk);
        m_bus.awaddr = 32'h2000_0000; m_bus.awvalid = 1; m_bus.wvalid = 1;
        #1;
        chk("wr_err2 m.wready", m_bus.wready, 1);
        @(negedge clk);
        m_bus.awvalid = 0; m_bus.wvalid = 0; m_bus.bready = 1;
        #1;
        chk("wr_err2 m.bvalid", m_bus.bvalid, 1);
        @(negedge clk);
        clear_all();

        // Read outstanding on S0 while a write completes on S1.
        @(negedge clk);
        m_bus.araddr = 32'h8000_0020; m_bus.arvalid = 1; s0_bus.arready = 1;
        @(negedge clk);
        m_bus.arvalid = 0; s0_bus.arready = 0;
        m_bus.awaddr = 32'h1000_0008; m_bus.awvalid = 1; m_bus.wvalid = 1; m_bus.wdata = 32'hA5;
        s1_bus.awready = 1; s1_bus.wready = 1;
        #1;
        chk("conc s1.awvalid", s1_bus.awvalid, 1);
        chk("conc s1.wvalid", s1_bus.wvalid, 1);
        chk("conc m.rvalid idle", m_bus.rvalid, 0);
        @(negedge clk);
        m_bus.awvalid = 0; m_bus.wvalid = 0; s1_bus.awready = 0; s1_bus.wready = 0;
        s1_bus.bvalid = 1; s1_bus.bresp = 2'b01; m_bus.bready = 1;
        #1;
        chk("conc m.bvalid", m_bus.bvalid, 1);
        chk("conc m.bresp", m_bus.bresp, 2'b01);
        chk("conc m.rvalid during B", m_bus.rvalid, 0);
        @(negedge clk);
        s1_bus.bvalid = 0; m_bus.bready = 0;
        s0_bus.rvalid = 1; s0_bus.rdata = 32'h1234_5678; s0_bus.rresp = 2'b00; m_bus.rready = 1;
        #1;
        chk("conc m.rvalid", m_bus.rvalid, 1);
        chk("conc m.rdata", m_bus.rdata, 32'h1234_5678);
        chk("conc s1.rready", s1_bus.rready, 0);
        @(negedge clk);
        clear_all();

        // Reset while in RD_WAIT.
        @(negedge clk);
        m_bus.araddr = 32'h8000_0030; m_bus.arvalid = 1; s0_bus.arready = 1;
        @(negedge clk);
        m_bus.arvalid = 0; s0_bus.arready = 0;
        #1;
        chk("rst_wait m.arready", m_bus.arready, 0);
        reset = 1;
        drive_busy();
        #1;
        chk_quiet("rst_mid");
        @(negedge clk);
        chk_quiet("rst_mid2");
        @(negedge clk);
        reset = 0;
        clear_all();
        m_bus.araddr = 32'h8000_0030; s0_bus.arready = 1;
        #1;
        chk("rst_after m.arready", m_bus.arready, 1);
        @(negedge clk);
        clear_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
